// File: rtl/pdh_pkg.sv
// Shared types and constants for the PDH sweep sequencer.
package pdh_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_PUSH    = 3'd4,
        ST_DONE    = 3'd5
    } sweep_state_t;

    localparam logic [13:0] DAC_MIDSCALE = 14'h2000;

    // Each ADC sample sits in the low bits of a 16-bit lane; two lanes per word.
    localparam int SAMPLE_LANE_WIDTH = 16;
    localparam int SAMPLE_WIDTH      = 2 * SAMPLE_LANE_WIDTH;

endpackage

// File: rtl/sweep_step_sat.sv
// Saturating DAC code stepper: next = code +/- step, clamped to the DAC rails.
module sweep_step_sat #(
    parameter int W = 14
) (
    input  logic [W-1:0] code_i,
    input  logic [W-1:0] step_i,
    input  logic         dir_i,
    output logic [W-1:0] next_o,
    output logic         clip_o
);

    logic [W:0] sum;
    logic [W:0] diff;

    always_comb begin
        sum  = {1'b0, code_i} + {1'b0, step_i};
        diff = {1'b0, code_i} - {1'b0, step_i};
        if (dir_i) begin
            // Borrow out of the extra bit means the result went below zero.
            clip_o = diff[W];
            next_o = diff[W] ? '0 : diff[W-1:0];
        end else begin
            clip_o = sum[W];
            next_o = sum[W] ? '1 : sum[W-1:0];
        end
    end

endmodule

// File: rtl/sweep_ctrl.sv
// DAC ramp sequencer: write, settle, capture both ADCs, hand sample downstream.
//   state   | meaning
//   IDLE    | waiting for start_i, config latched on start
//   WRITE   | dac_wrt_o strobe for the current code
//   SETTLE  | count down cfg_settle+1 cycles
//   CAPTURE | register both ADC channels
//   PUSH    | present sample until sample_ready_i
//   DONE    | one-cycle done_o pulse
module sweep_ctrl
    import pdh_pkg::*;
#(
    parameter int DAC_DATA_WIDTH = 14,
    parameter int ADC_DATA_WIDTH = 14,
    parameter int COUNT_WIDTH    = 16,
    parameter int SETTLE_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [DAC_DATA_WIDTH-1:0] cfg_start_i,
    input  logic [DAC_DATA_WIDTH-1:0] cfg_step_i,
    input  logic                      cfg_dir_i,
    input  logic [COUNT_WIDTH-1:0]    cfg_count_i,
    input  logic [SETTLE_WIDTH-1:0]   cfg_settle_i,
    input  logic                      cfg_chan_i,
    input  logic [ADC_DATA_WIDTH-1:0] adc_dat_a_i,
    input  logic [ADC_DATA_WIDTH-1:0] adc_dat_b_i,
    output logic [DAC_DATA_WIDTH-1:0] dac_dat_o,
    output logic                      dac_sel_o,
    output logic                      dac_wrt_o,
    output logic                      sample_valid_o,
    input  logic                      sample_ready_i,
    output logic [SAMPLE_WIDTH-1:0]   sample_data_o,
    output logic [COUNT_WIDTH-1:0]    sample_idx_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      clip_o
);

    localparam int PAD_WIDTH = SAMPLE_LANE_WIDTH - ADC_DATA_WIDTH;

    sweep_state_t              state_q, state_d;
    logic [DAC_DATA_WIDTH-1:0] step_q;
    logic                      dir_q;
    logic [COUNT_WIDTH-1:0]    count_q;
    logic [SETTLE_WIDTH-1:0]   settle_q;
    logic [SETTLE_WIDTH-1:0]   settle_cnt_q;
    logic [COUNT_WIDTH-1:0]    idx_q;
    logic [DAC_DATA_WIDTH-1:0] dac_dat_q;
    logic                      dac_sel_q;
    logic [SAMPLE_WIDTH-1:0]   sample_data_q;
    logic                      clip_q;

    logic [DAC_DATA_WIDTH-1:0] step_next;
    logic                      step_clip;
    logic                      last_pt;

    // dac_dat_q always holds the code of the point in flight, so it feeds the stepper.
    sweep_step_sat #(.W(DAC_DATA_WIDTH)) u_step (
        .code_i (dac_dat_q),
        .step_i (step_q),
        .dir_i  (dir_q),
        .next_o (step_next),
        .clip_o (step_clip)
    );

    assign last_pt = (idx_q == count_q - COUNT_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_i) state_d = (cfg_count_i == '0) ? ST_DONE : ST_WRITE;
            ST_WRITE:   state_d = ST_SETTLE;
            ST_SETTLE:  if (settle_cnt_q == '0) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_PUSH;
            ST_PUSH:    if (sample_ready_i) state_d = last_pt ? ST_DONE : ST_WRITE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort_i && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            step_q        <= '0;
            dir_q         <= 1'b0;
            count_q       <= '0;
            settle_q      <= '0;
            settle_cnt_q  <= '0;
            idx_q         <= '0;
            dac_dat_q     <= DAC_DATA_WIDTH'(DAC_MIDSCALE);
            dac_sel_q     <= 1'b0;
            sample_data_q <= '0;
            clip_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        step_q   <= cfg_step_i;
                        dir_q    <= cfg_dir_i;
                        count_q  <= cfg_count_i;
                        settle_q <= cfg_settle_i;
                        idx_q    <= '0;
                        clip_q   <= 1'b0;
                        if (cfg_count_i != '0) begin
                            dac_dat_q <= cfg_start_i;
                            dac_sel_q <= cfg_chan_i;
                        end
                    end
                end
                ST_WRITE:  settle_cnt_q <= settle_q;
                ST_SETTLE: if (settle_cnt_q != '0) settle_cnt_q <= settle_cnt_q - SETTLE_WIDTH'(1);
                ST_CAPTURE: begin
                    sample_data_q <= {{PAD_WIDTH{1'b0}}, adc_dat_b_i,
                                      {PAD_WIDTH{1'b0}}, adc_dat_a_i};
                end
                ST_PUSH: begin
                    // Only step on a handshake that continues the sweep (not last, not aborted).
                    if (state_d == ST_WRITE) begin
                        idx_q     <= idx_q + COUNT_WIDTH'(1);
                        dac_dat_q <= step_next;
                        clip_q    <= clip_q | step_clip;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dac_dat_o      = dac_dat_q;
    assign dac_sel_o      = dac_sel_q;
    assign dac_wrt_o      = (state_q == ST_WRITE);
    assign sample_valid_o = (state_q == ST_PUSH);
    assign sample_data_o  = sample_data_q;
    assign sample_idx_o   = idx_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_DONE);
    assign clip_o         = clip_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: a timeline model predicts writes, samples and done pulses.
module tb_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, abort_i;
    logic [13:0] cfg_start_i, cfg_step_i;
    logic        cfg_dir_i;
    logic [15:0] cfg_count_i, cfg_settle_i;
    logic        cfg_chan_i;
    logic [13:0] adc_dat_a_i, adc_dat_b_i;
    logic [13:0] dac_dat_o;
    logic        dac_sel_o, dac_wrt_o;
    logic        sample_valid_o, sample_ready_i;
    logic [31:0] sample_data_o;
    logic [15:0] sample_idx_o;
    logic        busy_o, done_o, clip_o;

    sweep_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .cfg_start_i    (cfg_start_i),
        .cfg_step_i     (cfg_step_i),
        .cfg_dir_i      (cfg_dir_i),
        .cfg_count_i    (cfg_count_i),
        .cfg_settle_i   (cfg_settle_i),
        .cfg_chan_i     (cfg_chan_i),
        .adc_dat_a_i    (adc_dat_a_i),
        .adc_dat_b_i    (adc_dat_b_i),
        .dac_dat_o      (dac_dat_o),
        .dac_sel_o      (dac_sel_o),
        .dac_wrt_o      (dac_wrt_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .sample_data_o  (sample_data_o),
        .sample_idx_o   (sample_idx_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .clip_o         (clip_o)
    );

    always #5 clk = ~clk;

    typedef struct { int c; int code; int sel; } wr_t;
    typedef struct { int c; int idx; logic [31:0] data; } sm_t;
    typedef struct { int c; int clip; } dn_t;
    typedef struct { int start; int step; int dir; int count; int settle; int chan; } cfg_t;

    wr_t wq[$];
    sm_t sq[$];
    dn_t dq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rdy_mode = 0;
    int lo_from = 0, lo_to = 0;
    int busy_lo = -1, busy_hi = -2;
    bit rdy_tbl [0:1023];
    bit mon_en = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit rdy_at(input int c);
        if (c >= lo_from && c < lo_to) return 1'b0;
        if (rdy_mode == 0) return 1'b1;
        return rdy_tbl[c % 1024];
    endfunction

    function automatic logic [13:0] adc_a_at(input int c);
        return 14'(c * 37 + 5);
    endfunction

    function automatic logic [13:0] adc_b_at(input int c);
        return 14'(c * 91 + 11);
    endfunction

    function automatic logic [31:0] sample_at(input int c);
        return {2'b00, adc_b_at(c), 2'b00, adc_a_at(c)};
    endfunction

    // Cycle counter and per-cycle input drive: ADC pattern and consumer readiness.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            adc_dat_a_i    = adc_a_at(cyc);
            adc_dat_b_i    = adc_b_at(cyc);
            sample_ready_i = rdy_at(cyc);
        end
    end

    wr_t mw;
    sm_t ms;
    dn_t md;
    logic        pv = 1'b0, phs = 1'b0;
    logic [31:0] pdata;
    logic [15:0] pidx;

    always @(negedge clk) begin
        if (mon_en) begin
            if (dac_wrt_o) begin
                if (wq.size() == 0) chk("write_unexpected", cyc, -1);
                else begin
                    mw = wq.pop_front();
                    chk("write_cycle", cyc, mw.c);
                    chk("write_code", dac_dat_o, mw.code);
                    chk("write_sel", dac_sel_o, mw.sel);
                end
            end
            if (sample_valid_o && sample_ready_i) begin
                if (sq.size() == 0) chk("sample_unexpected", cyc, -1);
                else begin
                    ms = sq.pop_front();
                    chk("sample_cycle", cyc, ms.c);
                    chk("sample_idx", sample_idx_o, ms.idx);
                    chk("sample_data", sample_data_o, ms.data);
                end
            end
            if (done_o) begin
                if (dq.size() == 0) chk("done_unexpected", cyc, -1);
                else begin
                    md = dq.pop_front();
                    chk("done_cycle", cyc, md.c);
                    chk("done_clip", clip_o, md.clip);
                end
            end
            if (pv && !phs && sample_valid_o) begin
                chk("hold_data", sample_data_o, pdata);
                chk("hold_idx", sample_idx_o, pidx);
            end
            if (busy_lo >= 0 && cyc >= busy_lo && cyc <= busy_hi + 1)
                chk("busy", busy_o, (cyc <= busy_hi) ? 1 : 0);
        end
        pv    = sample_valid_o;
        phs   = sample_valid_o && sample_ready_i;
        pdata = sample_data_o;
        pidx  = sample_idx_o;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_cfg(input cfg_t c);
        cfg_start_i  = 14'(c.start);
        cfg_step_i   = 14'(c.step);
        cfg_dir_i    = c.dir[0];
        cfg_count_i  = 16'(c.count);
        cfg_settle_i = 16'(c.settle);
        cfg_chan_i   = c.chan[0];
    endtask

    task automatic rand_cfg_pins();
        cfg_start_i  = 14'($urandom);
        cfg_step_i   = 14'($urandom);
        cfg_dir_i    = 1'($urandom);
        cfg_count_i  = 16'($urandom_range(0, 9));
        cfg_settle_i = 16'($urandom_range(0, 9));
        cfg_chan_i   = 1'($urandom);
    endtask

    // Reference timeline: start driven in cycle c0; sweep cut short by abort/reset in cycle stop.
    task automatic gen(input int c0, input cfg_t c, input int stop, output int e, output int fc);
        int code, w, cap, p, nxt;
        wr_t wr;
        sm_t sm;
        dn_t dn;
        code = c.start;
        fc   = 0;
        e    = stop;
        if (c.count == 0) begin
            if (c0 + 1 <= stop) begin
                dn.c = c0 + 1; dn.clip = 0; dq.push_back(dn); e = c0 + 1;
            end
            return;
        end
        w = c0 + 1;
        for (int k = 0; k < c.count; k++) begin
            if (w > stop) break;
            wr.c = w; wr.code = code; wr.sel = c.chan; wq.push_back(wr);
            cap = w + c.settle + 2;
            p   = cap + 1;
            if (p > stop) break;
            while (!rdy_at(p)) p++;
            if (p > stop) break;
            sm.c = p; sm.idx = k; sm.data = sample_at(cap); sq.push_back(sm);
            if (k == c.count - 1) begin
                if (p + 1 <= stop) begin
                    dn.c = p + 1; dn.clip = fc; dq.push_back(dn); e = p + 1;
                end
                break;
            end
            if (p == stop) break;
            if (c.dir == 0) begin
                nxt = code + c.step;
                if (nxt > 16383) begin nxt = 16383; fc = 1; end
            end else begin
                nxt = code - c.step;
                if (nxt < 0) begin nxt = 0; fc = 1; end
            end
            code = nxt;
            w = p + 1;
        end
    endtask

    task automatic launch(input cfg_t c, input int stop_rel, output int c0, output int e, output int fc);
        int stop;
        drive_cfg(c);
        start_i = 1'b1;
        c0 = cyc;
        stop = (stop_rel >= 0) ? c0 + stop_rel : 32'h3fff_ffff;
        gen(c0, c, stop, e, fc);
        busy_lo = c0 + 1;
        busy_hi = e;
        step();
        start_i = 1'b0;
        rand_cfg_pins();
    endtask

    task automatic finish_sweep(input int e, input int fc);
        while (cyc < e + 2) step();
        chk("drain_writes", wq.size(), 0);
        chk("drain_samples", sq.size(), 0);
        chk("drain_done", dq.size(), 0);
        chk("final_clip", clip_o, fc);
        busy_lo = -1;
    endtask

    task automatic run_sweep(input cfg_t c, input int abort_rel, input bit spur);
        int c0, e, fc, a, sp;
        launch(c, abort_rel, c0, e, fc);
        a  = (abort_rel >= 0) ? c0 + abort_rel : -1;
        sp = spur ? int'($urandom_range(e, c0 + 1)) : -1;
        while (cyc < e + 2) begin
            abort_i = (cyc == a);
            start_i = (cyc == sp);
            rand_cfg_pins();
            step();
        end
        abort_i = 1'b0;
        start_i = 1'b0;
        finish_sweep(e, fc);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dac_dat"}, dac_dat_o, 14'h2000);
        chk({tag, "_dac_sel"}, dac_sel_o, 0);
        chk({tag, "_dac_wrt"}, dac_wrt_o, 0);
        chk({tag, "_valid"}, sample_valid_o, 0);
        chk({tag, "_data"}, sample_data_o, 0);
        chk({tag, "_idx"}, sample_idx_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_clip"}, clip_o, 0);
    endtask

    cfg_t cf;
    int   c0, e, fc, a, r;

    initial begin
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        cfg_start_i = '0; cfg_step_i = '0; cfg_dir_i = 1'b0;
        cfg_count_i = '0; cfg_settle_i = '0; cfg_chan_i = 1'b0;
        adc_dat_a_i = '0; adc_dat_b_i = '0; sample_ready_i = 1'b1;
        for (int i = 0; i < 1024; i++)
            rdy_tbl[i] = ($urandom_range(0, 99) < 65) || (i % 8 == 0);
        repeat (3) step();
        rst = 1'b0;
        step();
        mon_en = 1'b1;
        check_reset_outputs("reset");

        // Basic up-ramp, ready held high.
        cf = '{'h1000, 'h100, 0, 3, 2, 0};
        run_sweep(cf, -1, 1'b0);

        // Up-step into the top rail, then exactly onto it without clipping.
        cf = '{'h3F80, 'h100, 0, 2, 1, 1};
        run_sweep(cf, -1, 1'b0);
        cf = '{'h3EFF, 'h100, 0, 2, 0, 0};
        run_sweep(cf, -1, 1'b0);

        // Down-step into zero; the sweep continues at the rail.
        cf = '{'h0080, 'h100, 1, 3, 1, 1};
        run_sweep(cf, -1, 1'b0);

        // Consumer stalls 10 cycles on the first sample.
        lo_from = cyc + 7;
        lo_to   = lo_from + 10;
        cf = '{'h2000, 'h10, 1, 3, 3, 0};
        run_sweep(cf, -1, 1'b0);
        lo_from = 0; lo_to = 0;

        // Abort two cycles into the settle of point 1.
        cf = '{'h0800, 'h40, 0, 3, 5, 1};
        launch(cf, 13, c0, e, fc);
        a = c0 + 13;
        while (cyc < a) step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_dac_hold", dac_dat_o, 'h840);
        chk("abort_sel_hold", dac_sel_o, 1);
        finish_sweep(e, fc);
        cf = '{'h1234, 'h21, 0, 2, 2, 0};
        run_sweep(cf, -1, 1'b0);

        // Zero-point sweep with a start pulse landing while busy.
        cf = '{'h0100, 'h1, 0, 0, 3, 1};
        run_sweep(cf, -1, 1'b1);

        // Reset while presenting point 2, after a clip has been recorded.
        cf = '{'h3F00, 'h200, 0, 4, 1, 1};
        r = 1 + 2 * (1 + 4) + 1 + 3;
        launch(cf, r, c0, e, fc);
        while (cyc < c0 + r) step();
        chk("clip_before_reset", clip_o, fc);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("midreset");
        finish_sweep(e, 0);

        // Randomized sweeps with random backpressure, aborts and stray starts.
        rdy_mode = 1;
        for (int n = 0; n < 25; n++) begin
            cf.start  = int'($urandom_range(0, 16383));
            cf.step   = int'($urandom_range(0, 16383) >> $urandom_range(0, 10));
            cf.dir    = int'($urandom_range(0, 1));
            cf.count  = int'($urandom_range(1, 6));
            cf.settle = int'($urandom_range(0, 5));
            cf.chan   = int'($urandom_range(0, 1));
            run_sweep(cf, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1,
                      1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
